// File: rtl/true_dual_port_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : true_dual_port_ram_pkg
// Description : Shared read-during-write encodings and clear-FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package true_dual_port_ram_pkg;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

endpackage
`default_nettype wire

// File: rtl/tdp_ram_port.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_port
// Description : One RAM port: write qualification and registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tdp_ram_port
    import true_dual_port_ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int RDW_MODE = READ_FIRST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic [DATA_W-1:0] rd_word_i,
    output logic              wr_o,
    output logic [DATA_W-1:0] dout_o
);

    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;

    assign wr_o = active_i && en_i && we_i;

    always_comb begin
        dout_d = dout_q;
        if (!active_i) begin
            dout_d = '0;
        end else if (en_i) begin
            // rd_word_i is the pre-edge array content, i.e. the old word
            if (we_i && (RDW_MODE == WRITE_FIRST)) begin
                dout_d = din_i;
            end else begin
                dout_d = rd_word_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule
`default_nettype wire

// File: rtl/true_dual_port_ram.sv
`default_nettype none
// ============================================================================
// Module      : true_dual_port_ram
// Description : True dual-port RAM with post-reset clear and port-A priority.
//               Optional macro COLLISION_DETECT_EN enables the collision pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module true_dual_port_ram
    import true_dual_port_ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int RDW_MODE = READ_FIRST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_a,
    input  logic              en_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_a,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_a,
    output logic [DATA_W-1:0] dout_b,
    output logic              init_busy,
    output logic              collision
);

    localparam int DEPTH = 2 ** ADDR_W;

    clr_state_e        state_q;
    clr_state_e        state_d;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [ADDR_W-1:0] clr_cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              ready;
    logic              wr_a;
    logic              wr_b;
    logic              wr_b_eff;
    logic [DATA_W-1:0] rd_word_a;
    logic [DATA_W-1:0] rd_word_b;

    assign ready     = (state_q == READY);
    assign init_busy = !ready;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Same-address double write: port A wins, port B is dropped
    assign wr_b_eff = wr_b && !(wr_a && (addr_a == addr_b));

    always_ff @(posedge clk) begin
        if (!ready) begin
            mem_q[clr_cnt_q] <= '0;
        end else begin
            if (wr_a) begin
                mem_q[addr_a] <= din_a;
            end
            if (wr_b_eff) begin
                mem_q[addr_b] <= din_b;
            end
        end
    end

    assign rd_word_a = mem_q[addr_a];
    assign rd_word_b = mem_q[addr_b];

    tdp_ram_port #(
        .DATA_W   (DATA_W),
        .RDW_MODE (RDW_MODE)
    ) u_port_a (
        .clk       (clk),
        .rst       (rst),
        .active_i  (ready),
        .en_i      (en_a),
        .we_i      (we_a),
        .din_i     (din_a),
        .rd_word_i (rd_word_a),
        .wr_o      (wr_a),
        .dout_o    (dout_a)
    );

    tdp_ram_port #(
        .DATA_W   (DATA_W),
        .RDW_MODE (RDW_MODE)
    ) u_port_b (
        .clk       (clk),
        .rst       (rst),
        .active_i  (ready),
        .en_i      (en_b),
        .we_i      (we_b),
        .din_i     (din_b),
        .rd_word_i (rd_word_b),
        .wr_o      (wr_b),
        .dout_o    (dout_b)
    );

`ifdef COLLISION_DETECT_EN
    logic collision_q;
    logic collision_d;

    always_comb begin
        collision_d = ready && en_a && en_b && (addr_a == addr_b) && (we_a || we_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;
`else
    assign collision = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_true_dual_port_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_true_dual_port_ram
// Description : Directed, table-driven self-checking bench for true_dual_port_ram.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_true_dual_port_ram;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int RDW    = 0;
`ifdef COLLISION_DETECT_EN
    localparam bit COL = 1'b1;
`else
    localparam bit COL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en_a = 1'b0, en_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
    logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
    logic [DATA_W-1:0] din_a = '0, din_b = '0;
    logic [DATA_W-1:0] dout_a, dout_b;
    logic              init_busy, collision;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    true_dual_port_ram #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .RDW_MODE (RDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_a      (en_a),
        .en_b      (en_b),
        .we_a      (we_a),
        .we_b      (we_b),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .din_a     (din_a),
        .din_b     (din_b),
        .dout_a    (dout_a),
        .dout_b    (dout_b),
        .init_busy (init_busy),
        .collision (collision)
    );

    typedef struct {
        logic              en_a, we_a;
        logic [ADDR_W-1:0] addr_a;
        logic [DATA_W-1:0] din_a;
        logic              en_b, we_b;
        logic [ADDR_W-1:0] addr_b;
        logic [DATA_W-1:0] din_b;
        bit                ca;
        logic [DATA_W-1:0] ea;
        bit                cb;
        logic [DATA_W-1:0] eb;
        bit                cc;
        logic              ec;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int ena, int wea, int aa, int da,
                                int enb, int web, int ab, int db,
                                int ca, int ea, int cb, int eb, int cc, int ec);
        vec_t v;
        v.en_a = ena[0];   v.we_a = wea[0];
        v.addr_a = ADDR_W'(aa); v.din_a = DATA_W'(da);
        v.en_b = enb[0];   v.we_b = web[0];
        v.addr_b = ADDR_W'(ab); v.din_b = DATA_W'(db);
        v.ca = ca[0]; v.ea = DATA_W'(ea);
        v.cb = cb[0]; v.eb = DATA_W'(eb);
        v.cc = cc[0]; v.ec = ec[0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        en_a = 1'b0; we_a = 1'b0; addr_a = '0; din_a = '0;
        en_b = 1'b0; we_b = 1'b0; addr_b = '0; din_b = '0;
    endtask

    // Counts rising edges until init_busy drops; douts must stay 0 throughout
    task automatic wait_ready(input string name, input int exp_cycles);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (init_busy) begin
                check({name, " dout_a in clear"}, 32'(dout_a), 32'd0);
                check({name, " dout_b in clear"}, 32'(dout_b), 32'd0);
            end
        end while (init_busy && n < 20);
        check({name, " clear cycles"}, n, exp_cycles);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0,0,0,0, 1,0,i,0, 0,0, 1,0, 1,0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1,1,i,i*8+32, 0,0,0,0, 1,(RDW == 1) ? i*8+32 : 0, 0,0, 1,0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1,0,i,0, 1,0,7-i,0, 1,i*8+32, 1,(7-i)*8+32, 1,0));
        vecs.push_back(mk(1,1,3,8'h55, 0,0,0,0, 1,(RDW == 1) ? 8'h55 : 8'h38, 0,0, 1,0));
        vecs.push_back(mk(1,1,3,8'hAA, 1,0,3,0, 1,(RDW == 1) ? 8'hAA : 8'h55, 1,8'h55, 1,COL));
        vecs.push_back(mk(0,0,0,0, 1,0,3,0, 0,0, 1,8'hAA, 1,0));
        vecs.push_back(mk(1,1,5,8'h11, 1,1,5,8'h22,
                          1,(RDW == 1) ? 8'h11 : 8'h48, 1,(RDW == 1) ? 8'h22 : 8'h48, 1,COL));
        vecs.push_back(mk(1,0,5,0, 1,0,5,0, 1,8'h11, 1,8'h11, 1,0));
        vecs.push_back(mk(0,1,0,8'hFF, 1,0,0,0, 1,8'h11, 1,8'h20, 1,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0, 1,8'h20, 0,0, 1,0));
        vecs.push_back(mk(1,1,1,8'h99, 1,1,6,8'h77,
                          1,(RDW == 1) ? 8'h99 : 8'h28, 1,(RDW == 1) ? 8'h77 : 8'h50, 1,0));
        vecs.push_back(mk(1,0,6,0, 1,0,1,0, 1,8'h77, 1,8'h99, 1,0));
        vecs.push_back(mk(1,0,2,0, 1,1,2,8'h33, 1,8'h30, 1,(RDW == 1) ? 8'h33 : 8'h30, 1,COL));
        vecs.push_back(mk(1,0,2,0, 0,0,0,0, 1,8'h33, 1,(RDW == 1) ? 8'h33 : 8'h30, 1,0));

        // Asynchronous reset, sampled before any clock edge
        #1 rst = 1'b1;
        #2;
        check("reset init_busy", 32'(init_busy), 32'd1);
        check("reset dout_a", 32'(dout_a), 32'd0);
        check("reset dout_b", 32'(dout_b), 32'd0);
        check("reset collision", 32'(collision), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_ready("initial", 8);

        for (int k = 0; k < vecs.size(); k++) begin
            en_a = vecs[k].en_a; we_a = vecs[k].we_a;
            addr_a = vecs[k].addr_a; din_a = vecs[k].din_a;
            en_b = vecs[k].en_b; we_b = vecs[k].we_b;
            addr_b = vecs[k].addr_b; din_b = vecs[k].din_b;
            @(posedge clk);
            #1;
            if (vecs[k].ca) check($sformatf("vec%0d dout_a", k), 32'(dout_a), 32'(vecs[k].ea));
            if (vecs[k].cb) check($sformatf("vec%0d dout_b", k), 32'(dout_b), 32'(vecs[k].eb));
            if (vecs[k].cc) check($sformatf("vec%0d collision", k), 32'(collision), 32'(vecs[k].ec));
        end
        drive_idle();

        // Reset from READY: async effect on outputs, then full clear
        rst = 1'b1;
        #1;
        check("ready-reset init_busy", 32'(init_busy), 32'd1);
        check("ready-reset dout_a", 32'(dout_a), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid-clear init_busy", 32'(init_busy), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        // Port writes held active for the whole clear must be ignored
        en_a = 1'b1; we_a = 1'b1; addr_a = 3'd0; din_a = 8'hFF;
        en_b = 1'b1; we_b = 1'b1; addr_b = 3'd1; din_b = 8'hEE;
        wait_ready("restart", 8);
        drive_idle();

        for (int i = 0; i < 8; i++) begin
            en_a = 1'b1; addr_a = ADDR_W'(i);
            en_b = 1'b1; addr_b = ADDR_W'(7 - i);
            @(posedge clk);
            #1;
            check($sformatf("post-clear A[%0d]", i), 32'(dout_a), 32'd0);
            check($sformatf("post-clear B[%0d]", 7 - i), 32'(dout_b), 32'd0);
        end
        drive_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
